shift_engine: RTL

//   Parametrised multi-cycle shifter for the signed ALU: shifts or rotates operand A or B
//   by a variable amount, STEP bit positions per clock, under a start/busy/done handshake.

---
 rtl/shift_pkg.sv | 21 ++
 rtl/shift_step.sv | 53 +++++
 rtl/shift_engine.sv | 128 ++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shifter: mode codes, FSM encoding and
// the legal-mode check used when an operation completes.
package shift_pkg;

    localparam logic [2:0] MODE_LSR = 3'b000;
    localparam logic [2:0] MODE_LSL = 3'b001;
    localparam logic [2:0] MODE_ASR = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_legal_mode(input logic [2:0] mode);
        return mode <= MODE_ROL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves the operand by 0..STEP positions in
// the selected mode and reports the last bit shifted out.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AMT_W = 5
) (
    input  logic [WIDTH-1:0] operand,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic             fill;
    logic [WIDTH:0]   rt;   // {result, carry} for right shifts
    logic [WIDTH:0]   lt;   // {carry, result} for left shifts
    logic [WIDTH-1:0] rr;
    logic [WIDTH-1:0] rl;

    always_comb begin
        fill = (mode == MODE_ASR) & operand[WIDTH-1];
        // A guard bit below/above the operand catches the bit that falls off.
        rt = (WIDTH+1)'({{WIDTH{fill}}, operand, 1'b0} >> amt);
        lt = (WIDTH+1)'(({1'b0, operand, {WIDTH{1'b0}}} << amt) >> WIDTH);
        rr = WIDTH'({operand, operand} >> amt);
        rl = WIDTH'(({operand, operand} << amt) >> WIDTH);

        result = operand;
        carry  = 1'b0;
        case (mode)
            MODE_LSR, MODE_ASR: begin
                result = rt[WIDTH:1];
                carry  = rt[0];
            end
            MODE_LSL: begin
                result = lt[WIDTH-1:0];
                carry  = lt[WIDTH];
            end
            MODE_ROR: begin
                result = rr;
                carry  = (amt != '0) & rr[WIDTH-1];
            end
            MODE_ROL: begin
                result = rl;
                carry  = (amt != '0) & rl[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shifter for the signed ALU: shifts/rotates A or B by up to WIDTH
// positions, STEP bits per clock, under a start/busy/done handshake.
module shift_engine
    import shift_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Op_Sel,
    input  logic [2:0]         Mode,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic               Shift_enable,
    input  logic               Abort,
    output logic               Busy,
    output logic [WIDTH-1:0]   Shift_Out,
    output logic               Shift_Flag,
    output logic               Carry_Out,
    output logic               Zero_Flag,
    output logic               Err_Flag
);

    localparam logic [SHAMT_W-1:0] STEP_V  = SHAMT_W'(STEP);
    localparam logic [SHAMT_W-1:0] WIDTH_V = SHAMT_W'(WIDTH);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   work;
    logic [2:0]         mode_r;
    logic [SHAMT_W-1:0] remaining;
    logic               carry_r;

    logic               start;
    logic [SHAMT_W-1:0] shamt_clamped;
    logic [SHAMT_W-1:0] step_amt;
    logic [WIDTH-1:0]   step_val;
    logic               step_carry;
    logic               legal_r;

    assign start         = Shift_enable & ~Abort;
    assign shamt_clamped = (Shamt > WIDTH_V) ? WIDTH_V : Shamt;
    assign step_amt      = (remaining < STEP_V) ? remaining : STEP_V;
    assign legal_r       = is_legal_mode(mode_r);
    assign Busy          = (state != ST_IDLE);

    shift_step #(.WIDTH(WIDTH), .AMT_W(SHAMT_W)) u_step (
        .operand (work),
        .mode    (mode_r),
        .amt     (step_amt),
        .result  (step_val),
        .carry   (step_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Zero-length and reserved-mode operations skip SHIFT so the flag appears
    // one edge after the start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = (shamt_clamped == '0 || !is_legal_mode(Mode)) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (Abort)                      state_nxt = ST_IDLE;
                else if (remaining <= STEP_V)   state_nxt = ST_DONE;
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work       <= '0;
            mode_r     <= MODE_LSR;
            remaining  <= '0;
            carry_r    <= 1'b0;
            Shift_Out  <= '0;
            Shift_Flag <= 1'b0;
            Carry_Out  <= 1'b0;
            Zero_Flag  <= 1'b0;
            Err_Flag   <= 1'b0;
        end else begin
            Shift_Flag <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        work      <= Op_Sel ? B : A;
                        mode_r    <= Mode;
                        remaining <= shamt_clamped;
                        carry_r   <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (!Abort) begin
                        work      <= step_val;
                        remaining <= remaining - step_amt;
                        carry_r   <= step_carry;
                    end
                end
                ST_DONE: begin
                    if (!Abort) begin
                        Shift_Flag <= 1'b1;
                        Err_Flag   <= ~legal_r;
                        Carry_Out  <= legal_r & carry_r;
                        // A reserved mode leaves the previous result in place.
                        if (legal_r) begin
                            Shift_Out <= work;
                            Zero_Flag <= (work == '0);
                        end else begin
                            Zero_Flag <= (Shift_Out == '0);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
